image_job_sequencer: RTL and testbench

Queues image-processing jobs and runs them one at a time on a single ImageProcessor instance. Each job holds an operation code, mirror flags and a translation. Per job, the block latches the job's configuration onto the processor's configuration inputs and holds it stable. It drives the processor's `ce` and tracks the processor's `buzy` flag to detect completion. It sits between the host/command logic and the ImageProcessor, and reports completion, start-timeout and queue-overflow status.

---
 rtl/image_job_sequencer_if.sv | 41 ++++
 rtl/image_job_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_image_job_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_job_sequencer_if.sv
// Host/processor-side bundle of the image job sequencer: job push fields,
// queue status, processor configuration/handshake and completion status.
interface image_job_sequencer_if #(
  parameter int WidthAddressSize  = 6,
  parameter int HeightAddressSize = 6,
  parameter int QueueAddressSize  = 2
);
  logic                          push;
  logic [2:0]                    pushOpcode;
  logic                          pushInvertX;
  logic                          pushInvertY;
  logic [WidthAddressSize-1:0]   pushTranslateX;
  logic [HeightAddressSize-1:0]  pushTranslateY;
  logic                          full;
  logic [QueueAddressSize:0]     queueCount;
  logic                          ce;
  logic [2:0]                    opcode;
  logic                          invertX;
  logic                          invertY;
  logic [WidthAddressSize-1:0]   translateX;
  logic [HeightAddressSize-1:0]  translateY;
  logic                          buzy;
  logic                          done;
  logic                          timeout;
  logic                          overflow;
  logic [7:0]                    jobsDone;

  // Host/command logic and processor model side.
  modport master (
    output push, pushOpcode, pushInvertX, pushInvertY, pushTranslateX, pushTranslateY, buzy,
    input  full, queueCount, ce, opcode, invertX, invertY, translateX, translateY,
           done, timeout, overflow, jobsDone
  );

  // Sequencer side.
  modport slave (
    input  push, pushOpcode, pushInvertX, pushInvertY, pushTranslateX, pushTranslateY, buzy,
    output full, queueCount, ce, opcode, invertX, invertY, translateX, translateY,
           done, timeout, overflow, jobsDone
  );
endinterface

// File: rtl/image_job_sequencer.sv
// Image job sequencer: a small circular job queue feeding one ImageProcessor.
// Each popped job's configuration is held on the processor inputs for the
// whole job; ce is driven and buzy tracked to detect completion.
//
// state | meaning
// Idle  | ce low; pops the queue head into the configuration registers
// Start | ce high; waiting for buzy to rise, bounded by StartTimeout cycles
// Run   | ce high; processor busy, waiting for buzy to fall
// Done  | ce low; one-cycle done pulse, jobsDone advanced
module image_job_sequencer #(
  parameter int WidthAddressSize  = 6,
  parameter int HeightAddressSize = 6,
  parameter int QueueAddressSize  = 2,
  parameter int StartTimeout      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  image_job_sequencer_if.slave bus
);

  localparam int QueueDepth = 1 << QueueAddressSize;
  localparam int TimerWidth = $clog2(StartTimeout + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(StartTimeout - 1);
  localparam logic [TimerWidth-1:0] TimerOne  = TimerWidth'(1);
  localparam logic [QueueAddressSize:0] CountOne    = (QueueAddressSize + 1)'(1);
  localparam logic [QueueAddressSize:0] CountAlmost = (QueueAddressSize + 1)'(QueueDepth - 1);
  localparam logic [QueueAddressSize-1:0] PtrOne    = QueueAddressSize'(1);

  typedef struct packed {
    logic [2:0]                   opcode;
    logic                         invertX;
    logic                         invertY;
    logic [WidthAddressSize-1:0]  translateX;
    logic [HeightAddressSize-1:0] translateY;
  } JobEntry;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Run   = 2'd2,
    Done  = 2'd3
  } SeqState;

  JobEntry                     queueMem [QueueDepth];
  logic [QueueAddressSize-1:0] writePtr;
  logic [QueueAddressSize-1:0] readPtr;
  logic [QueueAddressSize:0]   count;
  logic                        fullReg;
  logic                        overflowReg;

  SeqState                     state;
  logic [TimerWidth-1:0]       startTimer;
  JobEntry                     activeJob;
  logic                        ceReg;
  logic                        doneReg;
  logic                        timeoutReg;
  logic [7:0]                  jobsDoneReg;

  JobEntry                     newEntry;
  JobEntry                     headEntry;
  logic                        pushAccept;
  logic                        popFire;

  // Push is accepted only against the registered full flag, so a push in the
  // same cycle as a pop from a full queue is still dropped.
  always_comb begin
    newEntry.opcode     = bus.pushOpcode;
    newEntry.invertX    = bus.pushInvertX;
    newEntry.invertY    = bus.pushInvertY;
    newEntry.translateX = bus.pushTranslateX;
    newEntry.translateY = bus.pushTranslateY;
    headEntry  = queueMem[readPtr];
    pushAccept = bus.push && !fullReg;
    popFire    = (state == Idle) && (count != '0);
  end

  // Circular job queue: storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writePtr    <= '0;
      readPtr     <= '0;
      count       <= '0;
      fullReg     <= 1'b0;
      overflowReg <= 1'b0;
      for (int i = 0; i < QueueDepth; i++) begin
        queueMem[i] <= '0;
      end
    end else begin
      if (pushAccept) begin
        queueMem[writePtr] <= newEntry;
        writePtr           <= writePtr + PtrOne;
      end
      if (popFire) begin
        readPtr <= readPtr + PtrOne;
      end
      if (bus.push && fullReg) begin
        overflowReg <= 1'b1;
      end
      case ({pushAccept, popFire})
        2'b10: begin
          count   <= count + CountOne;
          fullReg <= (count == CountAlmost);
        end
        2'b01: begin
          count   <= count - CountOne;
          fullReg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Job sequencing FSM with registered processor enable, configuration and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= Idle;
      startTimer  <= '0;
      activeJob   <= '0;
      ceReg       <= 1'b0;
      doneReg     <= 1'b0;
      timeoutReg  <= 1'b0;
      jobsDoneReg <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        Idle: begin
          if (popFire) begin
            activeJob  <= headEntry;
            ceReg      <= 1'b1;
            startTimer <= '0;
            state      <= Start;
          end
        end
        Start: begin
          if (bus.buzy) begin
            startTimer <= '0;
            state      <= Run;
          end else if (startTimer == TimerLast) begin
            // Processor never acknowledged: drop the job without counting it.
            timeoutReg <= 1'b1;
            ceReg      <= 1'b0;
            startTimer <= '0;
            state      <= Idle;
          end else begin
            startTimer <= startTimer + TimerOne;
          end
        end
        Run: begin
          if (!bus.buzy) begin
            ceReg       <= 1'b0;
            doneReg     <= 1'b1;
            jobsDoneReg <= jobsDoneReg + 8'd1;
            state       <= Done;
          end
        end
        Done: begin
          state <= Idle;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

  assign bus.full       = fullReg;
  assign bus.queueCount = count;
  assign bus.overflow   = overflowReg;
  assign bus.ce         = ceReg;
  assign bus.done       = doneReg;
  assign bus.timeout    = timeoutReg;
  assign bus.jobsDone   = jobsDoneReg;
  assign bus.opcode     = activeJob.opcode;
  assign bus.invertX    = activeJob.invertX;
  assign bus.invertY    = activeJob.invertY;
  assign bus.translateX = activeJob.translateX;
  assign bus.translateY = activeJob.translateY;

endmodule

// File: tb/tb_image_job_sequencer.sv
// Bench for image_job_sequencer: directed job pushes, a behavioural processor
// model answering ce with buzy, and a scoreboard monitor that checks each
// started job's configuration and the completion counter.
module tb_image_job_sequencer;

  typedef struct packed {
    logic [2:0] op;
    logic       ix;
    logic       iy;
    logic [5:0] tx;
    logic [5:0] ty;
  } ExpJob;

  logic clk;
  logic rst;

  int   errors;
  int   checks;
  int   doneCount;
  logic [7:0] jobsExp;
  logic cePrev;
  ExpJob expQ[$];

  int   procDelay;
  int   procLen;
  bit   procHang;

  image_job_sequencer_if #(
    .WidthAddressSize (6),
    .HeightAddressSize(6),
    .QueueAddressSize (2)
  ) bus ();

  image_job_sequencer #(
    .WidthAddressSize (6),
    .HeightAddressSize(6),
    .QueueAddressSize (2),
    .StartTimeout     (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural ImageProcessor: raises buzy procDelay cycles after ce, holds it
  // procLen cycles, or never raises it when procHang is set.
  initial begin : procModel
    bus.buzy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.ce) begin
        if (procHang) begin
          for (int i = 0; i < 100 && bus.ce; i++) @(negedge clk);
        end else begin
          repeat (procDelay - 1) @(negedge clk);
          bus.buzy = 1'b1;
          repeat (procLen) @(negedge clk);
          bus.buzy = 1'b0;
          for (int i = 0; i < 100 && bus.ce; i++) @(negedge clk);
        end
      end
    end
  end

  // Scoreboard monitor: each ce rise is a job start and must match the next
  // expected job; each done pulse must advance jobsDone by one.
  always @(negedge clk) begin
    if (!rst) begin
      jobsExp = 8'd0;
      cePrev  = 1'b0;
    end else begin
      if (bus.ce && !cePrev) begin
        if (expQ.size() == 0) begin
          check("unexpected job start opcode", bus.opcode, -1);
        end else begin
          ExpJob e;
          e = expQ.pop_front();
          check("job config", {bus.opcode, bus.invertX, bus.invertY, bus.translateX, bus.translateY}, e);
        end
      end
      if (bus.done) begin
        doneCount++;
        jobsExp = jobsExp + 8'd1;
        check("jobsDone at done", bus.jobsDone, jobsExp);
      end
      cePrev = bus.ce;
    end
  end

  task automatic pushJob(input logic [2:0] op, input logic ix, input logic iy,
                         input logic [5:0] tx, input logic [5:0] ty, input bit accept);
    ExpJob e;
    bus.pushOpcode     = op;
    bus.pushInvertX    = ix;
    bus.pushInvertY    = iy;
    bus.pushTranslateX = tx;
    bus.pushTranslateY = ty;
    bus.push           = 1'b1;
    if (accept) begin
      e = '{op: op, ix: ix, iy: iy, tx: tx, ty: ty};
      expQ.push_back(e);
    end
    @(negedge clk);
    bus.push = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 300);
    check(name, bus.done, 1);
  endtask

  task automatic waitBusy(input string name);
    int n;
    n = 0;
    while (!bus.buzy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.buzy, 1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 rst = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk);
    check("reset overflow", bus.overflow, 0);
    check("reset timeout", bus.timeout, 0);
    check("reset jobsDone", bus.jobsDone, 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cycles;
    int holdBad;
    int n;
    int doneBefore;

    errors = 0; checks = 0; doneCount = 0;
    procDelay = 3; procLen = 20; procHang = 1'b0;
    rst = 1'b0;
    bus.push = 1'b0; bus.pushOpcode = '0; bus.pushInvertX = 1'b0; bus.pushInvertY = 1'b0;
    bus.pushTranslateX = '0; bus.pushTranslateY = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ce", bus.ce, 0);
    check("reset done", bus.done, 0);
    check("reset full", bus.full, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset timeout", bus.timeout, 0);
    check("reset queueCount", bus.queueCount, 0);
    check("reset jobsDone", bus.jobsDone, 0);
    check("reset config", {bus.opcode, bus.invertX, bus.invertY, bus.translateX, bus.translateY}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single job, one cycle of queue latency
    pushJob(3'b100, 1'b0, 1'b0, 6'd0, 6'd0, 1);
    check("t1 queueCount after push", bus.queueCount, 1);
    check("t1 ce before pop", bus.ce, 0);
    @(negedge clk);
    check("t1 ce after pop", bus.ce, 1);
    check("t1 queueCount after pop", bus.queueCount, 0);
    waitDone("t1 done seen");
    check("t1 ce at done", bus.ce, 0);
    check("t1 jobsDone", bus.jobsDone, 1);
    @(negedge clk);
    check("t1 done one cycle", bus.done, 0);

    // Fill while busy, then push into a full queue on the pop cycle
    procDelay = 1; procLen = 10;
    pushJob(3'd5, 1'b1, 1'b0, 6'd7, 6'd8, 1);
    waitBusy("tA leader busy");
    pushJob(3'd6, 1'b0, 1'b1, 6'd11, 6'd12, 1);
    pushJob(3'd7, 1'b1, 1'b1, 6'd13, 6'd14, 1);
    pushJob(3'd0, 1'b0, 1'b0, 6'd63, 6'd1, 1);
    pushJob(3'd2, 1'b1, 1'b0, 6'd2, 6'd63, 1);
    check("tA full", bus.full, 1);
    check("tA queueCount full", bus.queueCount, 4);
    check("tA overflow before", bus.overflow, 0);
    waitDone("tA leader done");
    @(negedge clk);
    check("tA full before pop", bus.full, 1);
    pushJob(3'd1, 1'b1, 1'b1, 6'd40, 6'd41, 0);
    check("tA queueCount push+pop full", bus.queueCount, 3);
    check("tA overflow push+pop full", bus.overflow, 1);
    check("tA full after pop", bus.full, 0);
    repeat (4) waitDone("tA drain done");
    check("tA jobsDone total", bus.jobsDone, 6);

    applyReset();

    // Four jobs in order, fifth dropped
    pushJob(3'd7, 1'b0, 1'b0, 6'd3, 6'd3, 1);
    waitBusy("tB leader busy");
    pushJob(3'd1, 1'b0, 1'b0, 6'd1, 6'd10, 1);
    pushJob(3'd2, 1'b0, 1'b1, 6'd2, 6'd20, 1);
    pushJob(3'd3, 1'b1, 1'b0, 6'd3, 6'd30, 1);
    pushJob(3'd4, 1'b1, 1'b1, 6'd4, 6'd40, 1);
    check("tB full after 4th", bus.full, 1);
    pushJob(3'd5, 1'b0, 1'b0, 6'd5, 6'd50, 0);
    check("tB overflow", bus.overflow, 1);
    check("tB queueCount after drop", bus.queueCount, 4);
    doneBefore = doneCount;
    repeat (5) waitDone("tB drain done");
    repeat (30) @(negedge clk);
    check("tB done pulses", doneCount - doneBefore, 5);
    check("tB jobsDone", bus.jobsDone, 5);
    check("tB queue drained", bus.queueCount, 0);

    applyReset();

    // Start timeout, then the next queued job runs normally
    procHang = 1'b1;
    pushJob(3'd2, 1'b1, 1'b0, 6'd3, 6'd4, 1);
    pushJob(3'd3, 1'b0, 1'b1, 6'd5, 6'd6, 1);
    check("t4 ce in start", bus.ce, 1);
    check("t4 queueCount", bus.queueCount, 1);
    cycles = 0;
    while (!bus.timeout && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("t4 start cycles to timeout", cycles, 15);
    check("t4 ce at timeout", bus.ce, 0);
    check("t4 jobsDone after timeout", bus.jobsDone, 0);
    procHang = 1'b0;
    procDelay = 2; procLen = 5;
    waitDone("t4 next job done");
    check("t4 jobsDone", bus.jobsDone, 1);
    check("t4 timeout sticky", bus.timeout, 1);

    // Configuration held during RUN while a new job is pushed
    procDelay = 1; procLen = 12;
    @(negedge clk);
    pushJob(3'd6, 1'b0, 1'b0, 6'd5, 6'd9, 1);
    waitBusy("t5 busy");
    pushJob(3'd1, 1'b1, 1'b1, 6'd33, 6'd2, 1);
    check("t5 queueCount", bus.queueCount, 1);
    holdBad = 0;
    n = 0;
    while (!bus.done && n < 100) begin
      if (bus.translateX != 6'd5) holdBad++;
      @(negedge clk);
      n++;
    end
    check("t5 done seen", bus.done, 1);
    if (bus.translateX != 6'd5) holdBad++;
    check("t5 translateX held", holdBad, 0);
    waitDone("t5 second done");
    check("t5 translateX new", bus.translateX, 33);

    // Asynchronous reset mid-RUN with jobs queued
    procDelay = 1; procLen = 20;
    @(negedge clk);
    pushJob(3'd3, 1'b0, 1'b0, 6'd8, 6'd8, 1);
    waitBusy("t6 busy");
    pushJob(3'd4, 1'b0, 1'b0, 6'd9, 6'd9, 1);
    pushJob(3'd5, 1'b0, 1'b0, 6'd10, 6'd10, 1);
    check("t6 queueCount before", bus.queueCount, 2);
    check("t6 ce before", bus.ce, 1);
    @(negedge clk);
    doneBefore = doneCount;
    #2 rst = 1'b0;
    expQ.delete();
    #1;
    check("t6 ce async", bus.ce, 0);
    check("t6 queueCount async", bus.queueCount, 0);
    check("t6 jobsDone async", bus.jobsDone, 0);
    check("t6 config async", {bus.opcode, bus.translateX}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("t6 no done after reset", doneCount - doneBefore, 0);
    check("t6 ce idle", bus.ce, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
